// File: rtl/bus_slave_mem.sv
// Word-addressed SRAM responder for the core I/D bus: single, INCR and WRAP transfers
// with per-beat ACK after WAIT_STATES idle cycles. Optional random extra waits: BUS_SLV_RAND_WAIT_EN.
module bus_slave_mem #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_STATES = 1,
  parameter int BURST_LEN   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADDR,
  input  logic [1:0]  BURST,
  input  logic        REQ,
  input  logic        WRB,
  input  logic [31:0] WDATA,
  input  logic [3:0]  BSTROBE,
  output logic [31:0] RDATA,
  output logic        ACK,
  output logic        STALL
);

  localparam logic [4:0]    WS_L      = 5'(WAIT_STATES);
  localparam logic [4:0]    BL_M1     = 5'(BURST_LEN - 1);
  localparam logic [AW-1:0] WRAP_MASK = AW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BEAT = 2'd2
  } state_t;

  logic [31:0]   mem [DEPTH];

  state_t        state_r, state_nxt_s;
  logic [AW-1:0] idx_r, idx_nxt_s, idx_adv_s;
  logic [4:0]    beats_r, beats_nxt_s;
  logic [4:0]    wait_r, wait_nxt_s;
  logic [4:0]    total_wait_s;
  logic          wrb_r, wrb_nxt_s;
  logic          wrap_r, wrap_nxt_s;
  logic [3:0]    strb_r, strb_nxt_s;
  logic [1:0]    extra_s;
  logic [31:0]   rdata_r;
  logic          ack_r, stall_r;

`ifdef BUS_SLV_RAND_WAIT_EN
  logic [15:0]   lfsr_r;

  // Free-running LFSR supplying 0..3 extra wait cycles per beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  assign extra_s = lfsr_r[1:0];
`else
  assign extra_s = 2'd0;
`endif

  assign total_wait_s = WS_L + {3'd0, extra_s};

  // WRAP keeps the upper index bits and rolls only the in-burst bits
  assign idx_adv_s = wrap_r ? ((idx_r & ~WRAP_MASK) | ((idx_r + AW'(1)) & WRAP_MASK))
                            : (idx_r + AW'(1));

  // Next-state and latched-request logic
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    beats_nxt_s = beats_r;
    wait_nxt_s  = wait_r;
    wrb_nxt_s   = wrb_r;
    wrap_nxt_s  = wrap_r;
    strb_nxt_s  = strb_r;
    case (state_r)
      S_IDLE: begin
        if (REQ) begin
          idx_nxt_s  = ADDR[AW+1:2];
          wrb_nxt_s  = WRB;
          strb_nxt_s = BSTROBE;
          wrap_nxt_s = (BURST == 2'b10);
          if ((BURST == 2'b01) || (BURST == 2'b10)) begin
            beats_nxt_s = BL_M1;
          end else begin
            beats_nxt_s = 5'd0;
          end
          if (total_wait_s == 5'd0) begin
            state_nxt_s = S_BEAT;
          end else begin
            state_nxt_s = S_WAIT;
            wait_nxt_s  = total_wait_s - 5'd1;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_r == 5'd0) begin
          state_nxt_s = S_BEAT;
        end else begin
          wait_nxt_s = wait_r - 5'd1;
        end
      end
      S_BEAT: begin
        if (beats_r == 5'd0) begin
          state_nxt_s = S_IDLE;
        end else begin
          beats_nxt_s = beats_r - 5'd1;
          idx_nxt_s   = idx_adv_s;
          if (total_wait_s == 5'd0) begin
            state_nxt_s = S_BEAT;
          end else begin
            state_nxt_s = S_WAIT;
            wait_nxt_s  = total_wait_s - 5'd1;
          end
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, request fields and registered bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      beats_r <= 5'd0;
      wait_r  <= 5'd0;
      wrb_r   <= 1'b0;
      wrap_r  <= 1'b0;
      strb_r  <= 4'd0;
      rdata_r <= 32'd0;
      ack_r   <= 1'b0;
      stall_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      beats_r <= beats_nxt_s;
      wait_r  <= wait_nxt_s;
      wrb_r   <= wrb_nxt_s;
      wrap_r  <= wrap_nxt_s;
      strb_r  <= strb_nxt_s;
      ack_r   <= (state_nxt_s == S_BEAT);
      stall_r <= (state_nxt_s != S_IDLE);
      if ((state_nxt_s == S_BEAT) && !wrb_nxt_s) begin
        rdata_r <= mem[idx_nxt_s];
      end
    end
  end

  // Byte-enabled write commits at the edge closing the ACK cycle; array is never reset
  always_ff @(posedge clk) begin
    if (rst && (state_r == S_BEAT) && wrb_r) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_r[b]) begin
          mem[idx_r][8*b +: 8] <= WDATA[8*b +: 8];
        end
      end
    end
  end

  assign RDATA = rdata_r;
  assign ACK   = ack_r;
  assign STALL = stall_r;

endmodule

// File: doc/bus_slave_mem.md
Name: bus_slave_mem

Overview:
- Word-addressed SRAM responder on the other end of the core's I/D bus (ADDR/BURST/REQ/WRB/WDATA/RDATA/ACK/STALL/BSTROBE).
- Accepts single, INCR and WRAP transfers from a CPU bus master and returns per-beat ACK with configurable wait states.
- Used as the instruction/data memory model in the SoC top and as the bus-protocol checker target in unit benches.

Parameters:
- DEPTH, 1024, memory size in 32-bit words (power of 2).
- AW, 10, word-index width, log2(DEPTH).
- WAIT_STATES, 1, idle cycles inserted before each beat's ACK (0..15).
- BURST_LEN, 4, beats per INCR/WRAP burst (power of 2, 2..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- ADDR  in  32  byte address; bits [1:0] ignored.
- BURST  in  2  00 single, 01 INCR, 10 WRAP, 11 reserved (treated as single).
- REQ  in  1  request valid.
- WRB  in  1  1 = write, 0 = read.
- WDATA  in  32  write data for the current beat.
- BSTROBE  in  4  byte enables for writes; bit i enables WDATA[8i+7:8i].
- RDATA  out  32  read data, valid when ACK=1.
- ACK  out  1  one-cycle beat-complete pulse.
- STALL  out  1  1 = responder busy, request not accepted.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; ACK=0; STALL=0; RDATA=0; counters cleared. Memory array is not reset; contents persist across reset.
- Acceptance: a request is taken on a rising edge with REQ=1 and STALL=0. ADDR, BURST, WRB and BSTROBE are latched. Index = ADDR[AW+1:2]; higher address bits alias modulo DEPTH.
- STALL is 1 in every state other than IDLE and is registered (high from the cycle after acceptance). STALL=0 in IDLE.
- FSM:
  - IDLE -> WAIT on acceptance if WAIT_STATES>0, else -> BEAT.
  - WAIT: wait_cnt counts WAIT_STATES cycles, then -> BEAT.
  - BEAT: ACK=1 for exactly 1 cycle.
    - Last beat -> IDLE.
    - Otherwise -> WAIT (or stays in BEAT when WAIT_STATES=0) with next address.
- Latency: with acceptance at edge T, the first ACK is high in cycle T+1+WAIT_STATES. Each subsequent burst beat follows WAIT_STATES+1 cycles after the previous one.
- Beat count: 1 for single/reserved, BURST_LEN for INCR/WRAP.
- INCR: index increments by 1 per beat and wraps modulo DEPTH at the array end.
- WRAP: the low log2(BURST_LEN) index bits increment modulo BURST_LEN; upper bits are held. Example: BURST_LEN=4, start 0x0C gives 0x0C, 0x00, 0x04, 0x08.
- Read: RDATA = mem[index] during the ACK cycle. Outside ACK, RDATA holds its last value. BSTROBE is ignored on reads.
- Write: on the ACK cycle edge, mem[index] is updated bytewise per latched BSTROBE from the WDATA presented in that cycle. The master must drive beat k's data while beat k's ACK is high. BSTROBE=0000 writes nothing but is still ACKed.
- REQ held or reasserted while STALL=1 is ignored. The master must hold REQ and its fields until a cycle with STALL=0.
- Back-to-back: in the cycle after the last ACK, state is IDLE with STALL=0; a new request can be accepted at that edge.
- Reset mid-burst: the burst is aborted immediately. Writes already committed remain; remaining beats never occur.

Optional Feature:
- Macro BUS_SLV_RAND_WAIT_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1 at reset, advanced every clk) adds 0..3 extra wait cycles per beat, taken from LFSR[1:0] sampled when entering WAIT/BEAT. This exercises master stall and ACK tolerance. All ordering and data rules are unchanged.
- Not defined: no LFSR is instantiated and waits are exactly WAIT_STATES.

Test Plan:
- Single write then read: write ADDR=0x10, WDATA=0xDEADBEEF, BSTROBE=1111, WAIT_STATES=1 -> ACK at T+2, STALL high T+1..T+2. Read of 0x10 -> RDATA=0xDEADBEEF with ACK at T+2.
- Byte strobe: word 0x20=0x11223344, write WDATA=0xAABBCCDD with BSTROBE=0101 -> read returns 0x11BB33DD.
- INCR burst: write 4 beats from 0x40 with data 1,2,3,4, then INCR read from 0x40 -> 4 ACKs spaced WAIT_STATES+1 apart, RDATA 1,2,3,4.
- WRAP burst: preload 0x00..0x0C with A,B,C,D, WRAP read from 0x08 -> RDATA C,D,A,B; STALL=0 the cycle after the 4th ACK.
- Stall/back-to-back: REQ held high continuously with changing fields during a burst -> only the first request is accepted; the next request is accepted on the first STALL=0 edge, with no dropped or duplicated ACK.
- Reset mid-burst: drop rst after the 2nd ACK of a 4-beat INCR write -> ACK=STALL=RDATA=0 immediately. After release, words 0 and 1 hold the new data and words 2 and 3 are unchanged.
